// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding, defaults and mask search helper for the BIST scheduler
package bist_pkg;

    localparam int NUM_ENG_DEF = 4;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ACK   = 3'd2,
        ST_RUN   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } bist_state_t;

    // Lowest set bit of mask at or above index from; -1 when none remain.
    function automatic int next_enabled(input logic [15:0] mask, input int from);
        int found;
        found = -1;
        for (int i = 15; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                found = i;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/bist_scheduler_if.sv
// rtl/bist_scheduler_if.sv - scheduler request/engine handshake bundle
interface bist_scheduler_if #(
    parameter int NUM_ENG = bist_pkg::NUM_ENG_DEF
);
    localparam int CW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    logic               sched_start;
    logic [NUM_ENG-1:0] eng_enable;
    logic [NUM_ENG-1:0] eng_running;
    logic [NUM_ENG-1:0] eng_bist_end;
    logic [NUM_ENG-1:0] eng_bist_start;
    logic               busy;
    logic               sched_done;
    logic [NUM_ENG-1:0] timeout_err;
    logic [CW-1:0]      cur_eng;

    modport master (
        output sched_start, eng_enable, eng_running, eng_bist_end,
        input  eng_bist_start, busy, sched_done, timeout_err, cur_eng
    );

    modport slave (
        input  sched_start, eng_enable, eng_running, eng_bist_end,
        output eng_bist_start, busy, sched_done, timeout_err, cur_eng
    );

endinterface

// File: rtl/bist_timeout_counter.sv
// rtl/bist_timeout_counter.sv - saturating per-run cycle counter with expiry flag
module bist_timeout_counter #(
    parameter int TIMEOUT = bist_pkg::TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] MAX  = W'(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Count enabled cycles since the last clear, holding at TIMEOUT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != MAX) begin
            cnt <= cnt + W'(1);
        end
    end

    // The current enabled cycle is the TIMEOUT-th one (or later) since the clear.
    assign expire = en && (cnt >= LAST);

endmodule

// File: rtl/bist_scheduler.sv
// rtl/bist_scheduler.sv - sequences enabled BIST engines in ascending order with per-engine timeout
module bist_scheduler
    import bist_pkg::*;
#(
    parameter int NUM_ENG = NUM_ENG_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    bist_scheduler_if.slave bus
);
    localparam int CW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    bist_state_t        state_q, state_d;
    logic               start_s1, start_s2;
    logic [NUM_ENG-1:0] mask_q, mask_d;
    logic [NUM_ENG-1:0] pulse_q, pulse_d;
    logic [NUM_ENG-1:0] err_q, err_d;
    logic [CW-1:0]      cur_q, cur_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tmo_clr, tmo_en, tmo_expire;
    logic               start_edge;
    int                 first_idx, next_idx;

    // Rising edge of the registered start request; the extra stage keeps the
    // accept one edge after the request is first sampled.
    assign start_edge = start_s1 && !start_s2;

    bist_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        err_d     = err_q;
        cur_d     = cur_q;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        first_idx = next_enabled(16'(bus.eng_enable), 0);
        next_idx  = next_enabled(16'(mask_q), int'(cur_q) + 1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    mask_d = bus.eng_enable;
                    err_d  = '0;
                    if (first_idx < 0) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = CW'(first_idx);
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                tmo_clr = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // bist_end is still high from the previous run here, so only running counts.
                tmo_en = 1'b1;
                if (bus.eng_running[cur_q]) begin
                    state_d = ST_RUN;
                end else if (tmo_expire) begin
                    err_d[cur_q] = 1'b1;
                    state_d      = ST_NEXT;
                end
            end
            ST_RUN: begin
                // Completion is checked first so it wins over a same-cycle expiry.
                tmo_en = 1'b1;
                if (bus.eng_bist_end[cur_q]) begin
                    state_d = ST_NEXT;
                end else if (tmo_expire) begin
                    err_d[cur_q] = 1'b1;
                    state_d      = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (next_idx < 0) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d   = CW'(next_idx);
                    state_d = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pulse_d = '0;
        if (state_d == ST_START) begin
            pulse_d[cur_d] = 1'b1;
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State, start history and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            mask_q   <= '0;
            pulse_q  <= '0;
            err_q    <= '0;
            cur_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_s1 <= bus.sched_start;
            start_s2 <= start_s1;
            mask_q   <= mask_d;
            pulse_q  <= pulse_d;
            err_q    <= err_d;
            cur_q    <= cur_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.eng_bist_start = pulse_q;
    assign bus.timeout_err    = err_q;
    assign bus.cur_eng        = cur_q;
    assign bus.busy           = busy_q;
    assign bus.sched_done     = done_q;

endmodule

// File: tb/tb_bist_scheduler.sv
// tb/tb_bist_scheduler.sv - self-checking bench for bist_scheduler
module tb_bist_scheduler;
    import bist_pkg::*;

    localparam int NE  = 4;
    localparam int TMO = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bist_scheduler_if #(.NUM_ENG(NE)) bus ();

    bist_scheduler #(.NUM_ENG(NE), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Engine behaviour: running rises cfg_rd cycles after the pulse (0 = never),
    // bist_end rises cfg_ed cycles after that and stays high (stale) until the
    // engine next raises running.
    logic [3:0][7:0] cfg_rd, cfg_ed;
    bit              eng_clear;
    int              cyc;
    int              run_at [NE];
    int              end_at [NE];
    bit              armed  [NE];
    logic [3:0]      p_vec [$];
    logic [1:0]      p_cur [$];
    int              p_cyc [$];

    initial begin
        bus.eng_running  = '0;
        bus.eng_bist_end = '0;
        cyc = 0;
        for (int e = 0; e < NE; e++) armed[e] = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (eng_clear) begin
                bus.eng_running  = '0;
                bus.eng_bist_end = '1;
                for (int e = 0; e < NE; e++) armed[e] = 1'b0;
                p_vec.delete();
                p_cur.delete();
                p_cyc.delete();
            end else begin
                if (bus.eng_bist_start != '0) begin
                    p_vec.push_back(bus.eng_bist_start);
                    p_cur.push_back(bus.cur_eng);
                    p_cyc.push_back(cyc);
                    for (int e = 0; e < NE; e++) begin
                        if (bus.eng_bist_start[e] && cfg_rd[e] != 8'd0) begin
                            armed[e]  = 1'b1;
                            run_at[e] = cyc + int'(cfg_rd[e]);
                            end_at[e] = run_at[e] + int'(cfg_ed[e]);
                        end
                    end
                end
                for (int e = 0; e < NE; e++) begin
                    if (armed[e] && cyc == run_at[e]) begin
                        bus.eng_running[e]  = 1'b1;
                        bus.eng_bist_end[e] = 1'b0;
                    end
                    if (armed[e] && cyc == end_at[e]) begin
                        bus.eng_running[e]  = 1'b0;
                        bus.eng_bist_end[e] = 1'b1;
                        armed[e]            = 1'b0;
                    end
                end
            end
        end
    end

    task automatic prepare(input logic [3:0] en, input logic [3:0][7:0] rd, input logic [3:0][7:0] ed);
        @(negedge clock);
        cfg_rd         = rd;
        cfg_ed         = ed;
        bus.eng_enable = en;
        eng_clear      = 1'b1;
        @(negedge clock);
        @(negedge clock);
        eng_clear      = 1'b0;
    endtask

    task automatic run_sched(input logic [3:0] en, input logic [3:0][7:0] rd, input logic [3:0][7:0] ed,
                             output bit got_done, output bit busy_seen);
        prepare(en, rd, ed);
        bus.sched_start = 1'b1;
        @(negedge clock);
        bus.sched_start = 1'b0;
        got_done  = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            @(negedge clock);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.sched_done && !bus.busy) got_done = 1'b1;
        end
    endtask

    task automatic check_pulses(input string tag, input logic [3:0][3:0] order, input int n);
        check({tag, " npulse"}, 32'(p_vec.size()), 32'(n));
        for (int j = 0; j < n && j < p_vec.size(); j++) begin
            check($sformatf("%s pulse%0d", tag, j), 32'(p_vec[j]), 32'(4'b0001 << order[j]));
            check($sformatf("%s cur%0d", tag, j), 32'(p_cur[j]), 32'(order[j]));
        end
    endtask

    typedef struct {
        logic [3:0]      en;
        logic [3:0][7:0] rd;
        logic [3:0][7:0] ed;
        logic [3:0]      err;
        logic [3:0][3:0] order;
        int              n;
        int              gap12;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit              done_ok, busy_seen, found;
        logic [3:0]      en, exp_err;
        logic [3:0][7:0] rdv, edv;
        logic [3:0][3:0] ord;
        int              n;

        bus.sched_start = 1'b0;
        bus.eng_enable  = '0;
        eng_clear       = 1'b1;
        cfg_rd          = '0;
        cfg_ed          = '0;

        tbl[0] = '{en: 4'b1111, rd: {8'd2, 8'd2, 8'd2, 8'd2}, ed: {8'd10, 8'd10, 8'd10, 8'd10},
                   err: 4'b0000, order: {4'd3, 4'd2, 4'd1, 4'd0}, n: 4, gap12: 0};
        tbl[1] = '{en: 4'b0101, rd: {8'd2, 8'd2, 8'd2, 8'd2}, ed: {8'd10, 8'd10, 8'd10, 8'd10},
                   err: 4'b0000, order: {4'd0, 4'd0, 4'd2, 4'd0}, n: 2, gap12: 0};
        tbl[2] = '{en: 4'b1111, rd: {8'd2, 8'd2, 8'd0, 8'd2}, ed: {8'd10, 8'd10, 8'd10, 8'd10},
                   err: 4'b0010, order: {4'd3, 4'd2, 4'd1, 4'd0}, n: 4, gap12: 22};
        tbl[3] = '{en: 4'b0000, rd: {8'd2, 8'd2, 8'd2, 8'd2}, ed: {8'd10, 8'd10, 8'd10, 8'd10},
                   err: 4'b0000, order: {4'd0, 4'd0, 4'd0, 4'd0}, n: 0, gap12: 0};
        tbl[4] = '{en: 4'b0011, rd: {8'd2, 8'd2, 8'd2, 8'd2}, ed: {8'd10, 8'd10, 8'd19, 8'd18},
                   err: 4'b0010, order: {4'd0, 4'd0, 4'd1, 4'd0}, n: 2, gap12: 0};
        tbl[5] = '{en: 4'b1000, rd: {8'd1, 8'd1, 8'd1, 8'd1}, ed: {8'd1, 8'd1, 8'd1, 8'd1},
                   err: 4'b0000, order: {4'd0, 4'd0, 4'd0, 4'd3}, n: 1, gap12: 0};

        // Reset state.
        repeat (3) @(negedge clock);
        check("reset outputs", 32'({bus.busy, bus.sched_done, bus.eng_bist_start, bus.timeout_err, bus.cur_eng}), 0);
        reset = 1'b1;

        // Empty mask from IDLE: DONE right after the accept edge, busy never set.
        prepare(4'b0000, '0, '0);
        bus.sched_start = 1'b1;
        @(negedge clock);
        bus.sched_start = 1'b0;
        check("empty done@k", 32'(bus.sched_done), 0);
        @(negedge clock);
        check("empty done@k+1", 32'(bus.sched_done), 1);
        check("empty busy@k+1", 32'(bus.busy), 0);

        // Accept latency and single-cycle pulse, started from DONE.
        prepare(4'b0001, {8'd2, 8'd2, 8'd2, 8'd2}, {8'd10, 8'd10, 8'd10, 8'd10});
        bus.sched_start = 1'b1;
        @(negedge clock);
        bus.sched_start = 1'b0;
        check("lat busy@k", 32'(bus.busy), 0);
        check("lat done@k", 32'(bus.sched_done), 1);
        @(negedge clock);
        check("lat busy@k+1", 32'(bus.busy), 1);
        check("lat pulse@k+1", 32'(bus.eng_bist_start), 32'(4'b0001));
        check("lat done@k+1", 32'(bus.sched_done), 0);
        @(negedge clock);
        check("lat pulse@k+2", 32'(bus.eng_bist_start), 0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_sched(tbl[i].en, tbl[i].rd, tbl[i].ed, done_ok, busy_seen);
            check($sformatf("tbl%0d done", i), 32'(done_ok), 1);
            check($sformatf("tbl%0d busy_seen", i), 32'(busy_seen), 32'(tbl[i].en != 4'b0000));
            check($sformatf("tbl%0d err", i), 32'(bus.timeout_err), 32'(tbl[i].err));
            check_pulses($sformatf("tbl%0d", i), tbl[i].order, tbl[i].n);
            if (tbl[i].gap12 != 0 && p_cyc.size() >= 3) begin
                check($sformatf("tbl%0d gap12", i), 32'(p_cyc[2] - p_cyc[1]), 32'(tbl[i].gap12));
            end
        end

        // Random schedules against the reference rule: enabled engines run in
        // ascending order, and one times out unless it finishes within TMO
        // cycles of its pulse.
        for (int t = 0; t < 12; t++) begin
            en      = 4'($urandom_range(0, 15));
            exp_err = '0;
            ord     = '0;
            n       = 0;
            for (int e = 0; e < NE; e++) begin
                rdv[e] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
                edv[e] = 8'($urandom_range(1, 24));
                if (en[e]) begin
                    ord[n] = 4'(e);
                    n++;
                    if (rdv[e] == 8'd0 || int'(rdv[e]) + int'(edv[e]) > TMO) exp_err[e] = 1'b1;
                end
            end
            run_sched(en, rdv, edv, done_ok, busy_seen);
            check($sformatf("rnd%0d done", t), 32'(done_ok), 1);
            check($sformatf("rnd%0d err", t), 32'(bus.timeout_err), 32'(exp_err));
            check_pulses($sformatf("rnd%0d", t), ord, n);
        end

        // Ignored start edge while busy, then reset during RUN of engine 1.
        prepare(4'b1111, {8'd2, 8'd2, 8'd2, 8'd2}, {8'd10, 8'd10, 8'd10, 8'd10});
        bus.sched_start = 1'b1;
        @(negedge clock);
        bus.sched_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock);
            if (bus.eng_running[0]) found = 1'b1;
        end
        check("abort wait run0", 32'(found), 1);
        bus.sched_start = 1'b1;
        @(negedge clock);
        bus.sched_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (bus.cur_eng == 2'd1 && bus.eng_running[1]) found = 1'b1;
        end
        check("abort wait run1", 32'(found), 1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort outputs", 32'({bus.busy, bus.sched_done, bus.eng_bist_start, bus.timeout_err, bus.cur_eng}), 0);
        check_pulses("abort", {4'd0, 4'd0, 4'd1, 4'd0}, 2);
        @(negedge clock);
        reset = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.busy || bus.eng_bist_start != '0) busy_seen = 1'b1;
        end
        check("abort no restart", 32'(busy_seen), 0);
        check("abort pulses after", 32'(p_vec.size()), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_scheduler.md
BIST_SCHEDULER -- requirements
Module: bist_scheduler

Interface
REQ-001 Parameter NUM_ENG, default 4: number of BIST engines sequenced, range 1..16.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles allowed per engine run, range 1..65535.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately regardless of clock.
REQ-005 sched_start  input  1  scheduler start request, acted on at its rising edge only.
REQ-006 eng_enable  input  NUM_ENG  per-engine run mask, sampled at accepted start.
REQ-007 eng_running  input  NUM_ENG  per-engine running status, used as start acknowledge.
REQ-008 eng_bist_end  input  NUM_ENG  per-engine completion level.
REQ-009 eng_bist_start  output  NUM_ENG  one-hot, single-cycle start pulse to the selected engine.
REQ-010 busy  output  1  high from accepted start until the DONE state is entered.
REQ-011 sched_done  output  1  high in DONE, held until the next accepted start.
REQ-012 timeout_err  output  NUM_ENG  sticky per-engine timeout flags, cleared at accepted start.
REQ-013 cur_eng  output  $clog2(NUM_ENG) bits (min 1)  index of the engine being sequenced.

Function
REQ-014 States SHALL be IDLE, START, ACK, RUN, NEXT and DONE; all outputs SHALL be registered.
REQ-015 IDLE or DONE with sched_start=1 and previous-cycle sched_start=0 -> latch eng_enable; clear timeout_err; select lowest enabled index -> START; no enabled bit -> DONE directly.
REQ-016 Start edges in START, ACK, RUN or NEXT SHALL be ignored and not queued.
REQ-017 START: eng_bist_start[cur_eng]=1 for exactly one cycle -> ACK; all other eng_bist_start bits stay 0.
REQ-018 ACK: eng_running[cur_eng]=1 -> RUN; eng_bist_end is ignored in ACK because it is stale from the previous run.
REQ-019 RUN: eng_bist_end[cur_eng]=1 -> NEXT.
REQ-020 Timeout counter clears on START and counts each ACK/RUN cycle; at TIMEOUT cycles without exit, set timeout_err[cur_eng] -> NEXT.
REQ-021 Same-cycle bist_end and timeout expiry: completion wins and no error is flagged.
REQ-022 NEXT: select the next higher enabled index in the latched mask -> START; none remaining -> DONE.
REQ-023 DONE: sched_done=1 and busy=0; selection order never wraps within one schedule.
REQ-024 Latency: start edge sampled at edge k -> busy=1 and eng_bist_start pulse after edge k+1; DONE is entered one cycle after the last NEXT.
REQ-025 Counter width SHALL be $clog2(TIMEOUT+1); it saturates and never wraps.
REQ-026 Inputs belonging to engines that are not selected SHALL be ignored.

Reset
REQ-027 reset low SHALL force IDLE, with busy=0, sched_done=0, eng_bist_start=0, timeout_err=0, cur_eng=0, counter=0, latched mask=0 and start-edge history=0.
REQ-028 Reset mid-schedule SHALL abort the schedule with no pulse generated; after release, a new rising edge of sched_start is required to start again.

Structure
REQ-029 Shared package bist_pkg SHALL hold the state encoding constants and the default NUM_ENG/TIMEOUT values.
REQ-030 One sub-module, bist_timeout_counter, SHALL provide clear, enable, saturate and expire behaviour and be parameterised by TIMEOUT.

Verification
REQ-031 NUM_ENG=4, enable=4'b1111, each engine raises running 2 cycles after its pulse and bist_end 10 cycles later -> pulses in order 0,1,2,3; sched_done=1; timeout_err=0.
REQ-032 enable=4'b0101 -> only engines 0 and 2 pulsed; cur_eng sequence 0,2; DONE reached.
REQ-033 TIMEOUT=20 and engine 1 never raises running -> timeout_err=4'b0010 after 20 ACK cycles; engine 2 pulsed next; sched_done=1.
REQ-034 enable=4'b0000 -> DONE one cycle after the start edge; no pulses; busy never asserted.
REQ-035 bist_end and timeout expire in the same cycle -> timeout_err bit remains 0.
REQ-036 reset low during RUN of engine 1, and a second start edge during busy -> immediate IDLE with all outputs 0; the start edge during busy is ignored.
